tx_lane_framer: RTL and testbench
=================================

# tx_lane_framer

Four-lane transmit framer and serializer: the upstream partner of the `Rx` deframer. It accepts payload bytes over a valid/ready handshake and frames each packet as COM, STP, striped DATA, END. Each 8-bit symbol is serialized MSB-first on lanes L0..L3 at one bit per clock. The lane outputs connect directly to the `Rx` inputs of the same names, and the `S` encoding matches what `Rx` reports.

## Interface
- `IDLE_SYM`, default 8'h7C: symbol sent on all lanes between packets.
- `COM_SYM`, default 8'hBC: comma symbol, all lanes, first symbol of a packet.
- `STP_SYM`, default 8'hFB: start-of-packet symbol, all lanes.
- `END_SYM`, default 8'hFD: end-of-packet symbol, all lanes.
- `PAD_SYM`, default 8'hF7: fills unused lanes of the final partial data group.
- `SKP_SYM`, default 8'h1C: sent on all lanes when a data group is not ready; the receiver discards it.
- `clk` input 1: single clock, all logic on posedge.
- `reset` input 1: asynchronous, active-low (reset asserted while 0).
- `enb` input 1: when 0, all state, counters and outputs hold; `ready`=0.
- `data_in` input 8: payload byte.
- `valid` input 1: `data_in`/`last` valid.
- `last` input 1: accompanying byte is the final payload byte of the packet.
- `ready` output 1: byte accepted at a posedge where `valid && ready`.
- `L0`,`L1`,`L2`,`L3` output 1 each: serial lane bits, MSB of the current lane shift register.
- `S` output 4: current symbol type. 0=IDLE, 1=COM, 2=STP, 3=DATA, 4=END, 5=SKP.

## Operation
- **Symbol counter.** `bitcnt` runs 0..7 while `enb`=1. A symbol boundary is the posedge where `bitcnt`==7. At a boundary the FSM updates, the next symbol loads into all four lane shift registers, and `bitcnt` wraps to 0. Otherwise each shift register shifts left by 1.
- **Group buffer.**
  - Holds four bytes plus a `count` (0..4) and a `closed` flag.
  - `ready` = `enb && count<4 && !closed`.
  - An accepted byte is written to slot `count`, and `count` increments. If `last`=1, `closed` is set.
  - The group is complete when `count`==4 or `closed`=1.
- **FSM.** Transitions are evaluated only at boundaries.
  - IDLE: if `count`>0 -> COM, else stay IDLE.
  - COM -> STP.
  - STP -> DATA.
  - DATA: if the previous loaded group was final -> END. Else, if the group is complete -> load it as DATA. Else -> load SKP and stay in DATA.
  - END -> IDLE.
- **Loading a data group.**
  - Lane k gets slot k; lanes at index `count` and above get `PAD_SYM`.
  - A group is final if `closed` was set.
  - The buffer clears (`count`=0, `closed`=0) at that same edge. A byte accepted on that exact edge lands in slot 0 of the new, empty buffer; it is never lost.
- **Control symbols.** COM, STP, END, IDLE and SKP are loaded identically on all four lanes.
- **Prefetch.** Bytes of the next packet may be accepted during END or IDLE. They trigger COM at the next boundary in IDLE.

## Timing
- **Reset values:**
  - state IDLE, `S`=0, `bitcnt`=0.
  - all shift registers = `IDLE_SYM`, so L0..L3 = 0.
  - `count`=0, `closed`=0, `ready`=0.
- **Reset mid-packet:** the packet aborts immediately with no END, and the buffer contents are discarded.
- **Latency from reset release:** after the first `enb`=1 clock, one full IDLE symbol (8 clocks) is sent.
- **Packet latency:** with a byte accepted during IDLE, COM begins at the next boundary (≤8 clocks later). The first DATA bit appears 16 clocks after COM starts.
- **Frame length:** a packet of N bytes with no stalls occupies 3 + ceil(N/4) symbols (COM, STP, DATA groups, END), each 8 clocks.
- **`S` timing:** `S` changes only at boundaries and reflects the symbol currently on the lanes.
- **Lane timing:** lane bits change only on posedge with `enb`=1.
- **`enb`=0 mid-symbol:** bit position and lane values freeze, and resume exactly where they stopped.

## Test plan
- **Reset:** hold `reset`=0, then release with `enb`=1 and `valid`=0 -> L0..L3 = 0, `S`=0; each lane repeats 01111100 continuously.
- **Single-byte packet:** one byte 0x01 with `last`=1 during IDLE.
  - All lanes send 10111100 (COM) then 11111011 (STP).
  - Next symbol: L0 = 00000001, L1..L3 = 11110111.
  - Then 11111101 (END) on all lanes, then IDLE; `S` steps 1,2,3,4,0.
- **Six-byte packet:** A1 B2 C3 D4 E5 F6, no stalls, `last` on F6.
  - Data group 1: lanes = A1, B2, C3, D4.
  - Data group 2: E5, F6, F7, F7.
  - Then END.
- **Source stall:** deliver 2 bytes, then hold `valid`=0 across a DATA boundary -> SKP (00011100) on all lanes with `S`=5; then the data resumes when 4 bytes are present.
- **Enable freeze:** drop `enb` for 5 clocks mid-COM -> lanes and `S` hold; the symbol completes with 8 serialized bits total after `enb` returns.
- **Async reset mid-DATA:** assert `reset`=0 between clock edges -> lanes go to 0, `S`=0 and `ready`=0 immediately; no END is emitted.

Source files
------------

// File: rtl/tx_lane_framer.sv
// Four-lane transmit framer: wraps payload bytes as COM, STP, striped DATA, END
// and shifts each 8-bit symbol out MSB-first, one bit per enabled clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | idle symbol on all lanes, waiting for a buffered payload byte
// COM     | comma symbol on all lanes
// STP     | start-of-packet symbol on all lanes
// DATA    | data group (or SKP while the group is incomplete)
// END     | end-of-packet symbol on all lanes
module tx_lane_framer #(
    parameter logic [7:0] IDLE_SYM = 8'h7C,
    parameter logic [7:0] COM_SYM  = 8'hBC,
    parameter logic [7:0] STP_SYM  = 8'hFB,
    parameter logic [7:0] END_SYM  = 8'hFD,
    parameter logic [7:0] PAD_SYM  = 8'hF7,
    parameter logic [7:0] SKP_SYM  = 8'h1C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [7:0] data_in,
    input  logic       valid,
    input  logic       last,
    output logic       ready,
    output logic       L0,
    output logic       L1,
    output logic       L2,
    output logic       L3,
    output logic [3:0] S
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_COM  = 3'd1;
    localparam logic [2:0] ST_STP  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_END  = 3'd4;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_COM  = 4'd1;
    localparam logic [3:0] S_STP  = 4'd2;
    localparam logic [3:0] S_DATA = 4'd3;
    localparam logic [3:0] S_END  = 4'd4;
    localparam logic [3:0] S_SKP  = 4'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] s_nxt;
    logic [2:0] bitcnt;
    logic [7:0] sr      [4];
    logic [7:0] sym_nxt [4];
    logic [7:0] grp     [4];
    logic [2:0] count;
    logic       closed;
    logic       final_grp;
    logic       final_nxt;
    logic       load_group;
    logic       boundary;
    logic       complete;
    logic       accept;

    assign boundary = enb && (bitcnt == 3'd7);
    assign complete = (count == 3'd4) || closed;
    // Reset is folded in so ready drops the moment reset asserts.
    assign ready    = reset && enb && (count < 3'd4) && !closed;
    assign accept   = valid && ready;

    assign L0 = sr[0][7];
    assign L1 = sr[1][7];
    assign L2 = sr[2][7];
    assign L3 = sr[3][7];

    always_comb begin
        state_nxt  = state;
        s_nxt      = S;
        final_nxt  = final_grp;
        load_group = 1'b0;
        for (int k = 0; k < 4; k++) sym_nxt[k] = IDLE_SYM;
        case (state)
            ST_IDLE: begin
                if (count != 3'd0) begin
                    state_nxt = ST_COM;
                    s_nxt     = S_COM;
                    for (int k = 0; k < 4; k++) sym_nxt[k] = COM_SYM;
                end else begin
                    s_nxt = S_IDLE;
                end
            end
            ST_COM: begin
                state_nxt = ST_STP;
                s_nxt     = S_STP;
                for (int k = 0; k < 4; k++) sym_nxt[k] = STP_SYM;
            end
            ST_STP, ST_DATA: begin
                state_nxt = ST_DATA;
                if (state == ST_DATA && final_grp) begin
                    state_nxt = ST_END;
                    s_nxt     = S_END;
                    final_nxt = 1'b0;
                    for (int k = 0; k < 4; k++) sym_nxt[k] = END_SYM;
                end else if (complete) begin
                    load_group = 1'b1;
                    s_nxt      = S_DATA;
                    final_nxt  = closed;
                    for (int k = 0; k < 4; k++)
                        sym_nxt[k] = (count > 3'(k)) ? grp[k] : PAD_SYM;
                end else begin
                    s_nxt = S_SKP;
                    for (int k = 0; k < 4; k++) sym_nxt[k] = SKP_SYM;
                end
            end
            ST_END: begin
                state_nxt = ST_IDLE;
                s_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                s_nxt     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            S         <= S_IDLE;
            bitcnt    <= 3'd0;
            final_grp <= 1'b0;
            for (int k = 0; k < 4; k++) sr[k] <= IDLE_SYM;
        end else if (enb) begin
            if (boundary) begin
                state     <= state_nxt;
                S         <= s_nxt;
                final_grp <= final_nxt;
                bitcnt    <= 3'd0;
                for (int k = 0; k < 4; k++) sr[k] <= sym_nxt[k];
            end else begin
                bitcnt <= bitcnt + 3'd1;
                for (int k = 0; k < 4; k++) sr[k] <= {sr[k][6:0], 1'b0};
            end
        end
    end

    // A byte arriving on the edge a group is loaded starts the fresh buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 3'd0;
            closed <= 1'b0;
            for (int k = 0; k < 4; k++) grp[k] <= 8'h00;
        end else if (load_group && boundary) begin
            count  <= {2'b00, accept};
            closed <= accept && last;
            if (accept) grp[0] <= data_in;
        end else if (accept) begin
            grp[count[1:0]] <= data_in;
            count           <= count + 3'd1;
            closed          <= last;
        end
    end

endmodule

// File: tb/tb_tx_lane_framer.sv
// Directed bench for tx_lane_framer: reads whole symbols off the lanes and
// compares them with hand-computed framing sequences.
module tb_tx_lane_framer;

    logic       clk;
    logic       reset;
    logic       enb;
    logic [7:0] data_in;
    logic       valid;
    logic       last;
    logic       ready;
    logic       L0, L1, L2, L3;
    logic [3:0] S;

    int checks = 0;
    int errors = 0;

    logic [7:0] fd [$];
    logic       fl [$];

    tx_lane_framer dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .data_in (data_in),
        .valid   (valid),
        .last    (last),
        .ready   (ready),
        .L0      (L0),
        .L1      (L1),
        .L2      (L2),
        .L3      (L3),
        .S       (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_feed();
        if (fd.size() > 0) begin
            valid   = 1'b1;
            data_in = fd[0];
            last    = fl[0];
        end else begin
            valid   = 1'b0;
            data_in = 8'h00;
            last    = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        fd.push_back(b);
        fl.push_back(l);
        drive_feed();
    endtask

    task automatic tick();
        logic acc;
        acc = valid && ready;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(fd.pop_front());
            void'(fl.pop_front());
        end
        drive_feed();
    endtask

    // Called just after a symbol boundary; returns just after the next one.
    task automatic chk_sym(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic [3:0] es, input int freeze_at);
        logic [7:0] w0, w1, w2, w3;
        logic       s_ok;
        w0 = 8'h00; w1 = 8'h00; w2 = 8'h00; w3 = 8'h00;
        s_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w0 = {w0[6:0], L0};
            w1 = {w1[6:0], L1};
            w2 = {w2[6:0], L2};
            w3 = {w3[6:0], L3};
            if (S !== es) s_ok = 1'b0;
            if (i == freeze_at) begin
                enb = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    check({tag, " frozen lanes"}, {28'd0, L3, L2, L1, L0},
                          {28'd0, e3[7-i], e2[7-i], e1[7-i], e0[7-i]});
                    check({tag, " frozen S"}, {28'd0, S}, {28'd0, es});
                    check({tag, " frozen ready"}, {31'd0, ready}, 32'd0);
                end
                enb = 1'b1;
            end
            tick();
        end
        check({tag, " L0"}, {24'd0, w0}, {24'd0, e0});
        check({tag, " L1"}, {24'd0, w1}, {24'd0, e1});
        check({tag, " L2"}, {24'd0, w2}, {24'd0, e2});
        check({tag, " L3"}, {24'd0, w3}, {24'd0, e3});
        check({tag, " S steady"}, {31'd0, s_ok}, 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        enb     = 1'b0;
        valid   = 1'b0;
        data_in = 8'h00;
        last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst lanes", {28'd0, L3, L2, L1, L0}, 32'd0);
        check("rst S", {28'd0, S}, 32'd0);
        check("rst ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        enb   = 1'b1;

        chk_sym("idle0", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("idle1", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);

        // single-byte packet
        push(8'h01, 1'b1);
        chk_sym("p1 idle", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("p1 com",  8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'd1, -1);
        chk_sym("p1 stp",  8'hFB, 8'hFB, 8'hFB, 8'hFB, 4'd2, -1);
        chk_sym("p1 data", 8'h01, 8'hF7, 8'hF7, 8'hF7, 4'd3, -1);
        chk_sym("p1 end",  8'hFD, 8'hFD, 8'hFD, 8'hFD, 4'd4, -1);
        chk_sym("p1 post", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);

        // six-byte packet, no stalls
        push(8'hA1, 1'b0); push(8'hB2, 1'b0); push(8'hC3, 1'b0);
        push(8'hD4, 1'b0); push(8'hE5, 1'b0); push(8'hF6, 1'b1);
        chk_sym("p6 idle", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("p6 com",  8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'd1, -1);
        chk_sym("p6 stp",  8'hFB, 8'hFB, 8'hFB, 8'hFB, 4'd2, -1);
        chk_sym("p6 grp1", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'd3, -1);
        chk_sym("p6 grp2", 8'hE5, 8'hF6, 8'hF7, 8'hF7, 4'd3, -1);
        chk_sym("p6 end",  8'hFD, 8'hFD, 8'hFD, 8'hFD, 4'd4, -1);

        // source stall: two bytes, then SKP until the group fills
        push(8'h11, 1'b0); push(8'h22, 1'b0);
        chk_sym("st idle", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("st com",  8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'd1, -1);
        chk_sym("st stp",  8'hFB, 8'hFB, 8'hFB, 8'hFB, 4'd2, -1);
        chk_sym("st skp1", 8'h1C, 8'h1C, 8'h1C, 8'h1C, 4'd5, -1);
        chk_sym("st skp2", 8'h1C, 8'h1C, 8'h1C, 8'h1C, 4'd5, -1);
        push(8'h33, 1'b0); push(8'h44, 1'b1);
        chk_sym("st skp3", 8'h1C, 8'h1C, 8'h1C, 8'h1C, 4'd5, -1);
        chk_sym("st data", 8'h11, 8'h22, 8'h33, 8'h44, 4'd3, -1);
        chk_sym("st end",  8'hFD, 8'hFD, 8'hFD, 8'hFD, 4'd4, -1);

        // enable freeze in the middle of COM
        push(8'h5A, 1'b1);
        chk_sym("fz idle", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("fz com",  8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'd1, 3);
        chk_sym("fz stp",  8'hFB, 8'hFB, 8'hFB, 8'hFB, 4'd2, -1);
        chk_sym("fz data", 8'h5A, 8'hF7, 8'hF7, 8'hF7, 4'd3, -1);
        chk_sym("fz end",  8'hFD, 8'hFD, 8'hFD, 8'hFD, 4'd4, -1);

        // async reset in the middle of DATA, with two extra bytes buffered
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
        push(8'h04, 1'b0); push(8'h05, 1'b0); push(8'h06, 1'b0);
        chk_sym("ar idle", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("ar com",  8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'd1, -1);
        chk_sym("ar stp",  8'hFB, 8'hFB, 8'hFB, 8'hFB, 4'd2, -1);
        check("ar data S", {28'd0, S}, 32'd3);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        fd.delete();
        fl.delete();
        drive_feed();
        #1;
        check("ar lanes", {28'd0, L3, L2, L1, L0}, 32'd0);
        check("ar S", {28'd0, S}, 32'd0);
        check("ar ready", {31'd0, ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_sym("ar post0", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);
        chk_sym("ar post1", 8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'd0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
